// File: rtl/lsu_mem.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory handshake, byte-lane steering, load extension.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN (adds o_misaligned_MEM).
module lsu_mem #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid_MEM,
  input  logic                 i_mem_read_MEM,
  input  logic                 i_mem_write_MEM,
  input  logic [2:0]           i_funct3_MEM,
  input  logic [WIDTH-1:0]     i_alu_result_MEM,
  input  logic [WIDTH-1:0]     i_write_data_MEM,
  output logic                 o_stall_MEM,
  output logic [WIDTH-1:0]     o_read_data_MEM,
  output logic                 o_load_valid_MEM,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [ADDR_W-1:0]    o_dmem_addr,
  output logic [WIDTH-1:0]     o_dmem_wdata,
  output logic [WIDTH/8-1:0]   o_dmem_be,
  input  logic                 i_dmem_gnt,
  input  logic                 i_dmem_rvalid,
  input  logic [WIDTH-1:0]     i_dmem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                 o_misaligned_MEM
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state;
  logic               access;
  logic [1:0]         a_in;
  logic               is_byte_in;
  logic               is_half_in;
  logic               misalign_in;
  logic [WIDTH/8-1:0] be_in;
  logic [WIDTH-1:0]   wdata_in;

  logic [1:0]         a_r;
  logic               byte_r;
  logic               half_r;
  logic               sign_r;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [WIDTH-1:0]   load_ext;

  assign access     = i_valid_MEM & (i_mem_read_MEM | i_mem_write_MEM);
  assign a_in       = i_alu_result_MEM[1:0];
  assign is_byte_in = (i_funct3_MEM[1:0] == 2'b00);
  assign is_half_in = (i_funct3_MEM[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_in = (is_half_in & a_in[0]) | (~is_byte_in & ~is_half_in & (a_in != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  always_comb begin
    be_in    = '1;
    wdata_in = i_write_data_MEM;
    if (is_byte_in) begin
      be_in    = 4'b0001 << a_in;
      wdata_in = {4{i_write_data_MEM[7:0]}};
    end else if (is_half_in) begin
      be_in    = 4'b0011 << {a_in[1], 1'b0};
      wdata_in = {2{i_write_data_MEM[15:0]}};
    end
  end

  always_comb begin
    byte_sel = 8'(i_dmem_rdata >> {a_r, 3'b000});
    half_sel = 16'(i_dmem_rdata >> {a_r[1], 4'b0000});
    load_ext = i_dmem_rdata;
    if (byte_r)
      load_ext = {{(WIDTH-8){sign_r & byte_sel[7]}}, byte_sel};
    else if (half_r)
      load_ext = {{(WIDTH-16){sign_r & half_sel[15]}}, half_sel};
  end

  assign o_stall_MEM = ((state == ST_IDLE) & access) | (state == ST_REQ) | (state == ST_WAIT);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_r;
  assign o_load_valid_MEM = (state == ST_DONE) & ~o_dmem_we & ~mis_r;
  assign o_misaligned_MEM = (state == ST_DONE) & mis_r;
`else
  assign o_load_valid_MEM = (state == ST_DONE) & ~o_dmem_we;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      o_dmem_req      <= 1'b0;
      o_dmem_we       <= 1'b0;
      o_dmem_addr     <= '0;
      o_dmem_wdata    <= '0;
      o_dmem_be       <= '0;
      o_read_data_MEM <= '0;
      a_r             <= '0;
      byte_r          <= 1'b0;
      half_r          <= 1'b0;
      sign_r          <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_r           <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            // write wins when both read and write are flagged
            o_dmem_we    <= i_mem_write_MEM;
            o_dmem_addr  <= {i_alu_result_MEM[ADDR_W-1:2], 2'b00};
            o_dmem_wdata <= wdata_in;
            o_dmem_be    <= be_in;
            a_r          <= a_in;
            byte_r       <= is_byte_in;
            half_r       <= is_half_in;
            sign_r       <= ~i_funct3_MEM[2];
`ifdef LSU_MISALIGN_TRAP_EN
            mis_r        <= misalign_in;
`endif
            if (misalign_in) begin
              state <= ST_DONE;
            end else begin
              o_dmem_req <= 1'b1;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (i_dmem_gnt) begin
            o_dmem_req <= 1'b0;
            if (o_dmem_we) begin
              state <= ST_DONE;
            end else if (i_dmem_rvalid) begin
              o_read_data_MEM <= load_ext;
              state           <= ST_DONE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_dmem_rvalid) begin
            o_read_data_MEM <= load_ext;
            state           <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Randomized bench for lsu_mem: responsive data-memory model with random grant/rvalid delays,
// expected lanes/addresses/load results computed from the access rules with plain arithmetic.
module tb_lsu_mem;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid_MEM;
  logic        i_mem_read_MEM;
  logic        i_mem_write_MEM;
  logic [2:0]  i_funct3_MEM;
  logic [31:0] i_alu_result_MEM;
  logic [31:0] i_write_data_MEM;
  logic        o_stall_MEM;
  logic [31:0] o_read_data_MEM;
  logic        o_load_valid_MEM;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        o_misaligned_MEM;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rd = '0;

  lsu_mem #(.WIDTH(32), .ADDR_W(32)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_valid_MEM      (i_valid_MEM),
    .i_mem_read_MEM   (i_mem_read_MEM),
    .i_mem_write_MEM  (i_mem_write_MEM),
    .i_funct3_MEM     (i_funct3_MEM),
    .i_alu_result_MEM (i_alu_result_MEM),
    .i_write_data_MEM (i_write_data_MEM),
    .o_stall_MEM      (o_stall_MEM),
    .o_read_data_MEM  (o_read_data_MEM),
    .o_load_valid_MEM (o_load_valid_MEM),
    .o_dmem_req       (o_dmem_req),
    .o_dmem_we        (o_dmem_we),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_wdata     (o_dmem_wdata),
    .o_dmem_be        (o_dmem_be),
    .i_dmem_gnt       (i_dmem_gnt),
    .i_dmem_rvalid    (i_dmem_rvalid),
    .i_dmem_rdata     (i_dmem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .o_misaligned_MEM (o_misaligned_MEM)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference rules: access size from funct3, lane = addr mod 4, extension by arithmetic.
  function automatic void model(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic [3:0] e_be, output logic [31:0] e_wd,
                                output logic [31:0] e_addr, output logic [31:0] e_ld,
                                output logic e_mis);
    int unsigned size, a, off;
    logic        sgn;
    logic [31:0] v;
    case (f3)
      3'b000:  begin size = 1; sgn = 1'b1; end
      3'b100:  begin size = 1; sgn = 1'b0; end
      3'b001:  begin size = 2; sgn = 1'b1; end
      3'b101:  begin size = 2; sgn = 1'b0; end
      default: begin size = 4; sgn = 1'b0; end
    endcase
    a      = addr % 4;
    e_addr = addr - 32'(a);
    e_mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e_mis  = (size == 2 && (a % 2) == 1) || (size == 4 && a != 0);
`endif
    if (size == 1) begin
      e_be = 4'(1 << a);
      e_wd = (wd % 256) * 32'h01010101;
      v    = (rd / (32'd1 << (8 * a))) % 256;
      e_ld = (sgn && v >= 128) ? v - 256 : v;
    end else if (size == 2) begin
      off  = (a / 2) * 2;
      e_be = 4'(3 << off);
      e_wd = (wd % 65536) * 32'h00010001;
      v    = (rd / (32'd1 << (8 * off))) % 65536;
      e_ld = (sgn && v >= 32768) ? v - 65536 : v;
    end else begin
      e_be = 4'hF;
      e_wd = wd;
      e_ld = rd;
    end
  endfunction

  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd);
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_addr, e_ld;
    logic        e_mis;
    int          e_stall, stalls, reqs, post;
    logic        granted, done;
    model(f3, addr, wd, rd, e_be, e_wd, e_addr, e_ld, e_mis);
    e_stall = e_mis ? 1 : 2 + gd + (st ? 0 : rvd);
    stalls = 0; reqs = 0; post = 0; granted = 1'b0; done = 1'b0;
    i_valid_MEM      = 1'b1;
    i_mem_write_MEM  = st;
    i_mem_read_MEM   = st ? 1'($urandom_range(0, 1)) : 1'b1;
    i_funct3_MEM     = f3;
    i_alu_result_MEM = addr;
    i_write_data_MEM = wd;
    i_dmem_rdata     = rd;
    #1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (o_stall_MEM) begin
        stalls++;
        check("load_valid_busy", 32'(o_load_valid_MEM), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misaligned_busy", 32'(o_misaligned_MEM), 32'd0);
`endif
        if (o_dmem_req) begin
          check("addr", o_dmem_addr, e_addr);
          check("be", 32'(o_dmem_be), 32'(e_be));
          check("we", 32'(o_dmem_we), 32'(st));
          if (st) check("wdata", o_dmem_wdata, e_wd);
          if (reqs == gd) begin
            i_dmem_gnt = 1'b1;
            granted    = 1'b1;
            if (!st && rvd == 0) i_dmem_rvalid = 1'b1;
          end
          reqs++;
        end else if (granted && !st) begin
          post++;
          if (post == rvd) i_dmem_rvalid = 1'b1;
        end
      end else begin
        done = 1'b1;
        check("stall_cycles", 32'(stalls), 32'(e_stall));
        check("req_cycles", 32'(reqs), e_mis ? 32'd0 : 32'(gd + 1));
        check("load_valid", 32'(o_load_valid_MEM), 32'(!st && !e_mis));
        if (!st && !e_mis) exp_rd = e_ld;
        check("read_data", o_read_data_MEM, exp_rd);
        check("req_done", 32'(o_dmem_req), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misaligned", 32'(o_misaligned_MEM), 32'(e_mis));
`endif
        i_valid_MEM     = 1'b0;
        i_mem_read_MEM  = 1'b0;
        i_mem_write_MEM = 1'b0;
      end
      @(posedge i_clk); #1;
      i_dmem_gnt    = 1'b0;
      i_dmem_rvalid = 1'b0;
      @(negedge i_clk); #1;
    end
    check("txn_complete", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] f3;
    logic       st;
    i_rst_n = 1'b0; i_valid_MEM = 1'b0; i_mem_read_MEM = 1'b0; i_mem_write_MEM = 1'b0;
    i_funct3_MEM = '0; i_alu_result_MEM = '0; i_write_data_MEM = '0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_stall", 32'(o_stall_MEM), 32'd0);
    check("rst_req", 32'(o_dmem_req), 32'd0);
    check("rst_read_data", o_read_data_MEM, 32'd0);
    check("rst_load_valid", 32'(o_load_valid_MEM), 32'd0);
    check("rst_be", 32'(o_dmem_be), 32'd0);
    check("rst_addr", o_dmem_addr, 32'd0);
    i_rst_n = 1'b1;

    // Reset while a load waits for rvalid; the late rvalid must be dropped.
    @(negedge i_clk); #1;
    i_valid_MEM = 1'b1; i_mem_read_MEM = 1'b1; i_funct3_MEM = 3'b001; i_alu_result_MEM = 32'h102;
    @(posedge i_clk); #1;
    @(negedge i_clk); #1;
    check("wr_req", 32'(o_dmem_req), 32'd1);
    i_dmem_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    @(negedge i_clk); #1;
    check("wait_stall", 32'(o_stall_MEM), 32'd1);
    i_valid_MEM = 1'b0; i_mem_read_MEM = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(o_stall_MEM), 32'd0);
    check("arst_req", 32'(o_dmem_req), 32'd0);
    @(negedge i_clk); #1;
    i_rst_n = 1'b1;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h80010000;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); #1;
      check("late_rvalid_lv", 32'(o_load_valid_MEM), 32'd0);
      check("late_rvalid_rd", o_read_data_MEM, 32'd0);
    end

    run_txn(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
    run_txn(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1, 0);
    run_txn(1'b0, 3'b000, 32'h101, 32'h0, 32'h0000F000, 0, 0);
    run_txn(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000F000, 0, 0);
    run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 3, 2);
    run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0, 1);
    run_txn(1'b1, 3'b001, 32'h301, 32'h0000BEEF, 32'h0, 2, 0);

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      run_txn(st, f3, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
